alu_muldiv_seq: RTL and testbench
=================================

// Module: alu_muldiv_seq
// PURPOSE
//  Iterative multiply/divide unit for the RISC V processor's RV32M extension.
//  It sits beside the single-cycle alu in the execute stage. The core hands it
//  an operation through a valid/ready handshake and stalls until the result
//  returns through a second valid/ready handshake.
//  It computes one bit per cycle (shift-add multiply, restoring divide) and is
//  parametrised in datapath width.
// PARAMETERS
//  XLEN     32   operand/result width in bits; must be >= 4
//  CNT_W    $clog2(XLEN)+1   iteration counter width (derived; do not override)
// PORTS
//  clk        in   1     rising-edge clock
//  rst_n      in   1     asynchronous active-low reset
//  in_valid   in   1     operation request valid
//  in_ready   out  1     unit can accept a request (high only in IDLE)
//  op_sel     in   3     0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//  src1       in   XLEN  rs1 operand (multiplicand / dividend)
//  src2       in   XLEN  rs2 operand (multiplier / divisor)
//  flush      in   1     abandon any operation in flight
//  out_valid  out  1     result valid (high only in DONE)
//  out_ready  in   1     consumer takes the result
//  result     out  XLEN  result; held stable while out_valid && !out_ready
//  busy       out  1     state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; busy=0; result=0; all internal registers 0.
//  FSM states:
//   IDLE: accept when in_valid && in_ready. Latch op_sel, |src1|, |src2| and the sign flags.
//    If the op is a special case, go to DONE. Otherwise go to CALC with cnt=XLEN.
//   CALC: one iteration per edge; cnt decrements; at cnt==1 the next state is DONE.
//   DONE: out_valid=1; on out_ready go to IDLE (no same-cycle accept of a new op).
//  Latency (acceptance cycle = cycle 0):
//   Normal ops: out_valid is first high in cycle XLEN+1.
//   Special cases: out_valid is first high in cycle 1.
//  Signedness:
//   MUL, MULH, DIV, REM: both operands signed.
//   MULHSU: src1 signed, src2 unsigned.
//   MULHU, DIVU, REMU: both operands unsigned.
//   Magnitudes are iterated unsigned. The sign is applied when the result is registered in DONE.
//  Multiply:
//   2*XLEN product register.
//   MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
//   Sign fix: the full 2*XLEN product is negated when the sign flags differ.
//  Divide:
//   Quotient sign = s1^s2. Remainder sign = sign of the dividend.
//   Remainder magnitude is always < |divisor|.
//  Special cases (no CALC):
//   Divide by zero: DIV/DIVU return all ones; REM/REMU return src1.
//   Signed overflow (src1 = -2^(XLEN-1), src2 = -1): DIV returns src1; REM returns 0.
//   MUL-type ops with src1==0 or src2==0 return 0.
//  flush:
//   Synchronous. Any state goes to IDLE next edge and out_valid drops; the result is discarded.
//   flush has priority over in_valid and out_ready in the same cycle.
//   A flush in IDLE together with in_valid causes no accept.
//  Reset asserted mid-operation: immediate return to reset values; no partial result is visible.
//  Inputs src1/src2/op_sel are ignored outside the accept cycle (changing them mid-CALC has no effect).
//  Backpressure: result, out_valid stay constant until out_ready; no timeout.
//  in_ready = (state==IDLE) && !flush.
// TESTING
//  MUL 7 x -3 (0x00000007, 0xFFFFFFFD)
//   -> result 0xFFFFFFEB; out_valid first high exactly 33 cycles after accept.
//  MULH / MULHU / MULHSU of 0x80000000 x 0xFFFFFFFF
//   -> MULH 0x00000000, MULHU 0x7FFFFFFF, MULHSU 0x80000000.
//  DIV / REM -7 / 2
//   -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1).
//   DIVU 0xFFFFFFFF / 2 -> 0x7FFFFFFF.
//  Divide by zero:
//   DIV 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 0x00000005; both with 1-cycle latency.
//  Overflow:
//   DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0; both with 1-cycle latency.
//  Control:
//   Assert flush at CALC cycle 10 -> IDLE next edge; in_ready=1; no out_valid.
//   Hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0.
//   Assert rst_n=0 mid-CALC -> all outputs at reset values immediately.

Source files
------------

// File: rtl/alu_muldiv_seq_if.sv
// Request/response handshake bundle between the execute stage and the
// iterative multiply/divide unit.
interface alu_muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op_sel;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, op_sel, src1, src2, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op_sel, src1, src2, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, sign applied when the result is stored.
module alu_muldiv_seq #(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    output logic busy,
    alu_muldiv_seq_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q;
    logic                s1_q, s2_q;
    logic [XLEN-1:0]     b_q;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [XLEN-1:0]     result_q;

    logic                accept;
    logic                sign1, sign2;
    logic [XLEN-1:0]     mag1, mag2;
    logic                div_zero, overflow, mul_zero, special;
    logic [XLEN-1:0]     special_result;
    logic [XLEN:0]       mul_sum, div_trial, div_diff;
    logic [2*XLEN-1:0]   prod_signed;
    logic [XLEN-1:0]     quo, rem, final_result;

    assign bus.in_ready  = (state_q == IDLE) && !flush;
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign busy          = (state_q != IDLE);
    assign accept        = bus.in_valid && bus.in_ready;

    // Operand decode at acceptance: signedness per op, magnitudes, special cases.
    always_comb begin
        sign1 = bus.src1[XLEN-1] & (bus.op_sel[2] ? ~bus.op_sel[0] : (bus.op_sel[1:0] != 2'b11));
        sign2 = bus.src2[XLEN-1] & (bus.op_sel[2] ? ~bus.op_sel[0] : ~bus.op_sel[1]);
        mag1  = sign1 ? -bus.src1 : bus.src1;
        mag2  = sign2 ? -bus.src2 : bus.src2;
        div_zero = (bus.src2 == '0);
        overflow = bus.op_sel[2] & ~bus.op_sel[0] &
                   (bus.src1 == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.src2);
        mul_zero = ~bus.op_sel[2] & ((bus.src1 == '0) | (bus.src2 == '0));
        special  = bus.op_sel[2] ? (div_zero | overflow) : mul_zero;
        special_result = '0;
        if (bus.op_sel[2]) begin
            if (div_zero)
                special_result = bus.op_sel[1] ? bus.src1 : '1;
            else
                special_result = bus.op_sel[1] ? '0 : bus.src1;
        end
    end

    // One iteration of the active algorithm plus the signed result it would yield.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? b_q : '0)};
        div_trial = prod_q[2*XLEN-1:XLEN-1];
        div_diff  = div_trial - {1'b0, b_q};
        if (!op_q[2])
            prod_d = {mul_sum, prod_q[XLEN-1:1]};
        else if (!div_diff[XLEN])
            prod_d = {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
        else
            prod_d = {div_trial[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};

        prod_signed = (s1_q ^ s2_q) ? -prod_d : prod_d;
        quo = prod_d[XLEN-1:0];
        rem = prod_d[2*XLEN-1:XLEN];
        case (op_q)
            3'd0:         final_result = prod_signed[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:         final_result = prod_signed[2*XLEN-1:XLEN];
            3'd4, 3'd5:   final_result = (s1_q ^ s2_q) ? -quo : quo;
            default:      final_result = s1_q ? -rem : rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = special ? DONE : CALC;
                CALC:    if (cnt_q == CNT_W'(1)) state_d = DONE;
                DONE:    if (bus.out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // The final iteration and the sign fix land on the same edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            b_q      <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (state_q == IDLE) begin
            if (accept) begin
                op_q   <= bus.op_sel;
                s1_q   <= sign1;
                s2_q   <= sign2;
                b_q    <= mag2;
                prod_q <= {{XLEN{1'b0}}, mag1};
                cnt_q  <= CNT_W'(XLEN);
                if (special)
                    result_q <= special_result;
            end
        end else if (state_q == CALC && !flush) begin
            prod_q <= prod_d;
            cnt_q  <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1))
                result_q <= final_result;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed vector bench for alu_muldiv_seq: result/latency table plus
// flush, backpressure, mid-operation input change and mid-operation reset.
module tb_alu_muldiv_seq;

    localparam int XLEN = 32;

    logic clk;
    logic rst_n;
    logic flush;
    logic busy;

    alu_muldiv_seq_if #(.XLEN(XLEN)) bus ();

    alu_muldiv_seq #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .busy  (busy),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expected;
        int          latency;
    } vec_t;

    vec_t vectors[$];

    int compared   = 0;
    int mismatched = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drive one request, return the result and the cycle index of first out_valid.
    task automatic applyStimulus(input string name, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic take,
                                 output logic [31:0] res, output int lat);
        @(negedge clk);
        checkOutput({name, " in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op_sel   = op;
        bus.src1     = a;
        bus.src2     = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = -1;
        res = '0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = c;
                res = bus.result;
                break;
            end
        end
        if (take && lat > 0) begin
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] res;
        int          lat;

        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op_sel    = 3'd0;
        bus.src1      = '0;
        bus.src2      = '0;
        bus.out_ready = 1'b0;

        vectors.push_back('{"MUL 7*-3",        3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33});
        vectors.push_back('{"MUL 12345*1000",  3'd0, 32'd12345,    32'd1000,     32'h00BC5EA8, 33});
        vectors.push_back('{"MULH",            3'd1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33});
        vectors.push_back('{"MULHU",           3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 33});
        vectors.push_back('{"MULHSU",          3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33});
        vectors.push_back('{"MULHU max*max",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
        vectors.push_back('{"DIV -7/2",        3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33});
        vectors.push_back('{"REM -7/2",        3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33});
        vectors.push_back('{"DIV 7/-2",        3'd4, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33});
        vectors.push_back('{"REM 7/-2",        3'd6, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33});
        vectors.push_back('{"DIVU max/2",      3'd5, 32'hFFFFFFFF, 32'h00000002, 32'h7FFFFFFF, 33});
        vectors.push_back('{"REMU 100/7",      3'd7, 32'd100,      32'd7,        32'd2,        33});
        vectors.push_back('{"DIV 5/0",         3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
        vectors.push_back('{"REMU 5/0",        3'd7, 32'd5,        32'd0,        32'h00000005, 1});
        vectors.push_back('{"DIV overflow",    3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        vectors.push_back('{"REM overflow",    3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
        vectors.push_back('{"MUL 0*x",         3'd0, 32'd0,        32'h00001234, 32'h00000000, 1});

        #12;
        checkOutput("reset in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset busy",      32'(busy),          32'd0);
        checkOutput("reset result",    bus.result,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vectors[i]) begin
            applyStimulus(vectors[i].name, vectors[i].op, vectors[i].a, vectors[i].b,
                          1'b1, res, lat);
            checkOutput({vectors[i].name, " result"}, res, vectors[i].expected);
            checkOutput({vectors[i].name, " latency"}, 32'(lat), 32'(vectors[i].latency));
        end

        // Flush at CALC cycle 10 abandons the multiply.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op_sel   = 3'd0;
        bus.src1     = 32'd7;
        bus.src2     = 32'd3;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("flush busy",      32'(busy),          32'd0);
        lat = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.out_valid) lat++;
        end
        checkOutput("flush no out_valid", 32'(lat), 32'd0);

        // Flush together with in_valid in IDLE must not accept.
        @(negedge clk);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.src1     = 32'd5;
        bus.src2     = 32'd0;
        bus.op_sel   = 3'd4;
        #1;
        checkOutput("flush idle in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("flush idle busy",      32'(busy),          32'd0);
        checkOutput("flush idle out_valid", 32'(bus.out_valid), 32'd0);

        // Inputs changed mid-CALC are ignored; result held under backpressure.
        fork
            applyStimulus("DIVU 100/7 hold", 3'd5, 32'd100, 32'd7, 1'b0, res, lat);
            begin
                repeat (3) @(negedge clk);
                bus.src1   = 32'hDEADBEEF;
                bus.src2   = 32'd1;
                bus.op_sel = 3'd0;
            end
        join
        checkOutput("hold first result", res, 32'd14);
        checkOutput("hold latency", 32'(lat), 32'd33);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("hold result",    bus.result,         32'd14);
            checkOutput("hold out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("hold in_ready",  32'(bus.in_ready),  32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checkOutput("release in_ready", 32'(bus.in_ready), 32'd1);

        // Reset asserted mid-CALC returns to reset values immediately.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op_sel   = 3'd0;
        bus.src1     = 32'd9;
        bus.src2     = 32'd9;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("pre-reset busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("mid reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mid reset busy",      32'(busy),          32'd0);
        checkOutput("mid reset result",    bus.result,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("MUL after reset", 3'd0, 32'd6, 32'd7, 1'b1, res, lat);
        checkOutput("MUL after reset result", res, 32'd42);
        checkOutput("MUL after reset latency", 32'(lat), 32'd33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
